// File: rtl/video_crop_window_if.sv
`default_nettype none
// ============================================================================
// Module   : video_crop_window_if
// Purpose  : Video stream, window configuration and status bundle for the
//            crop stage.
// Revision : 1.0
// ============================================================================
interface video_crop_window_if #(
  parameter int DATA_WIDTH = 24,
  parameter int X_WIDTH    = 12,
  parameter int Y_WIDTH    = 12
);
  logic [X_WIDTH-1:0]    start_x;
  logic [Y_WIDTH-1:0]    start_y;
  logic [X_WIDTH-1:0]    end_x;
  logic [Y_WIDTH-1:0]    end_y;
  logic                  hs_i;
  logic                  vs_i;
  logic                  de_i;
  logic [DATA_WIDTH-1:0] data_i;
  logic                  hs_o;
  logic                  vs_o;
  logic                  de_o;
  logic [DATA_WIDTH-1:0] data_o;
  logic                  cfg_err;
  logic                  frame_done;
  logic [Y_WIDTH-1:0]    out_lines;

  modport slave (
    input  start_x, start_y, end_x, end_y, hs_i, vs_i, de_i, data_i,
    output hs_o, vs_o, de_o, data_o, cfg_err, frame_done, out_lines
  );

  modport master (
    output start_x, start_y, end_x, end_y, hs_i, vs_i, de_i, data_i,
    input  hs_o, vs_o, de_o, data_o, cfg_err, frame_done, out_lines
  );
endinterface
`default_nettype wire

// File: rtl/video_crop_window.sv
`default_nettype none
// ============================================================================
// Module   : video_crop_window
// Purpose  : Frame-shadowed rectangular crop [start,end) with 1-cycle latency
//            and per-frame line summary. Define CROP_FILL_EN for letterbox
//            mode (outside pixels replaced by FILL_COLOR instead of dropped).
// Revision : 1.0
// ============================================================================
module video_crop_window #(
  parameter int                    DATA_WIDTH = 24,
  parameter int                    X_WIDTH    = 12,
  parameter int                    Y_WIDTH    = 12,
  parameter logic [DATA_WIDTH-1:0] FILL_COLOR = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  video_crop_window_if.slave   bus
);

`ifdef CROP_FILL_EN
  localparam bit C_FILL_EN = 1'b1;
`else
  localparam bit C_FILL_EN = 1'b0;
`endif

  typedef enum logic [0:0] {
    WAIT_FRAME = 1'b0,
    ACTIVE     = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic                  vs_d_q, de_d_q;
  logic [X_WIDTH-1:0]    sx_q, ex_q, x_q, x_d;
  logic [Y_WIDTH-1:0]    sy_q, ey_q, y_q, y_d;
  logic                  cfg_err_q, cfg_err_d;
  logic                  line_hit_q, line_hit_d;
  logic [Y_WIDTH-1:0]    line_cnt_q, line_cnt_d;
  logic [Y_WIDTH-1:0]    out_lines_q, out_lines_d;
  logic                  hs_q, vs_q, de_q, de_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  frame_done_q, frame_done_d;

  logic w_vs_rise, w_de_fall, w_active, w_in_win;

  assign w_vs_rise = bus.vs_i & ~vs_d_q;
  assign w_de_fall = ~bus.de_i & de_d_q;
  assign w_active  = (state_q == ACTIVE);
  // Pre-increment coordinates: x_q/y_q are the position of the current pixel.
  assign w_in_win  = bus.de_i & ~cfg_err_q & w_active &
                     (x_q >= sx_q) & (x_q < ex_q) &
                     (y_q >= sy_q) & (y_q < ey_q);

  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    cfg_err_d    = cfg_err_q;
    line_hit_d   = line_hit_q;
    line_cnt_d   = line_cnt_q;
    out_lines_d  = out_lines_q;
    frame_done_d = 1'b0;
    if (w_vs_rise) begin
      state_d      = ACTIVE;
      x_d          = '0;
      y_d          = '0;
      cfg_err_d    = (bus.start_x >= bus.end_x) | (bus.start_y >= bus.end_y);
      line_hit_d   = 1'b0;
      line_cnt_d   = '0;
      frame_done_d = w_active;
      if (w_active) out_lines_d = line_cnt_q;
    end else if (w_de_fall) begin
      x_d        = '0;
      line_hit_d = 1'b0;
      if (y_q != '1) y_d = y_q + 1'b1;
      if (line_hit_q && (line_cnt_q != '1)) line_cnt_d = line_cnt_q + 1'b1;
    end else begin
      if (bus.de_i && (x_q != '1)) x_d = x_q + 1'b1;
      if (w_in_win) line_hit_d = 1'b1;
    end
  end

  always_comb begin
    de_d   = C_FILL_EN ? (bus.de_i & w_active) : w_in_win;
    data_d = '0;
    if (w_in_win)
      data_d = bus.data_i;
    else if (C_FILL_EN && bus.de_i && w_active)
      data_d = FILL_COLOR;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= WAIT_FRAME;
      vs_d_q       <= 1'b0;
      de_d_q       <= 1'b0;
      sx_q         <= '0;
      sy_q         <= '0;
      ex_q         <= '0;
      ey_q         <= '0;
      x_q          <= '0;
      y_q          <= '0;
      cfg_err_q    <= 1'b0;
      line_hit_q   <= 1'b0;
      line_cnt_q   <= '0;
      out_lines_q  <= '0;
      hs_q         <= 1'b0;
      vs_q         <= 1'b0;
      de_q         <= 1'b0;
      data_q       <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      vs_d_q       <= bus.vs_i;
      de_d_q       <= bus.de_i;
      if (w_vs_rise) begin
        sx_q <= bus.start_x;
        sy_q <= bus.start_y;
        ex_q <= bus.end_x;
        ey_q <= bus.end_y;
      end
      x_q          <= x_d;
      y_q          <= y_d;
      cfg_err_q    <= cfg_err_d;
      line_hit_q   <= line_hit_d;
      line_cnt_q   <= line_cnt_d;
      out_lines_q  <= out_lines_d;
      hs_q         <= bus.hs_i;
      vs_q         <= bus.vs_i;
      de_q         <= de_d;
      data_q       <= data_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.hs_o       = hs_q;
  assign bus.vs_o       = vs_q;
  assign bus.de_o       = de_q;
  assign bus.data_o     = data_q;
  assign bus.cfg_err    = cfg_err_q;
  assign bus.frame_done = frame_done_q;
  assign bus.out_lines  = out_lines_q;

endmodule
`default_nettype wire

// File: tb/tb_video_crop_window.sv
`default_nettype none
// ============================================================================
// Module   : tb_video_crop_window
// Purpose  : Randomised frame-level bench for video_crop_window against a
//            coordinate-based reference model.
// Revision : 1.0
// ============================================================================
module tb_video_crop_window;
  localparam int          DW   = 24;
  localparam int          XW   = 12;
  localparam int          YW   = 12;
  localparam logic [23:0] FILL = 24'h0000FF;

  logic clk = 1'b0;
  logic rst = 1'b1;

  video_crop_window_if #(.DATA_WIDTH(DW), .X_WIDTH(XW), .Y_WIDTH(YW)) bus();

  video_crop_window #(
    .DATA_WIDTH(DW), .X_WIDTH(XW), .Y_WIDTH(YW), .FILL_COLOR(FILL)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          r;
    int          c;
    logic [23:0] d;
  } pix_t;

  logic [23:0]      fdata [0:15][0:15];
  pix_t             obs_q[$];
  pix_t             exp_q[$];
  int               fd_seen;
  logic [YW-1:0]    lines_seen;
  int               sync_bad;
  logic [DW+YW+4:0] rst_snap;
  int               checks = 0;
  int               errors = 0;

  // One input cycle: apply inputs, clock, then capture what the DUT produced
  // for them. r/c = -1 marks a blanking cycle.
  task automatic cyc(input logic hs, input logic vs, input logic de,
                     input logic [23:0] d, input int r, input int c);
    pix_t p;
    bus.hs_i   = hs;
    bus.vs_i   = vs;
    bus.de_i   = de;
    bus.data_i = d;
    @(posedge clk);
    #1;
    if (bus.de_o) begin
      p.r = r; p.c = c; p.d = bus.data_o;
      obs_q.push_back(p);
    end
    if (bus.frame_done) begin
      fd_seen++;
      lines_seen = bus.out_lines;
    end
    if (bus.hs_o !== hs || bus.vs_o !== vs) sync_bad++;
  endtask

  task automatic send_frame(input int w, input int h, input int chg_row = -1,
                            input logic [XW-1:0] new_sx = '0,
                            input int rst_row = -1, input bit no_vs = 1'b0);
    obs_q.delete();
    fd_seen = 0;
    for (int r = 0; r < h; r++)
      for (int c = 0; c < w; c++) fdata[r][c] = 24'($urandom);
    if (!no_vs) begin
      cyc(1'b0, 1'b1, 1'b0, '0, -1, -1);
      cyc(1'b0, 1'b1, 1'b0, '0, -1, -1);
    end
    cyc(1'b0, 1'b0, 1'b0, '0, -1, -1);
    cyc(1'b0, 1'b0, 1'b0, '0, -1, -1);
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        if (r == chg_row && c == 0) bus.start_x = new_sx;
        if (r == rst_row && c == 0) rst = 1'b1;
        cyc(1'b0, 1'b0, 1'b1, fdata[r][c], r, c);
        if (rst) begin
          rst = 1'b0;
          rst_snap = {bus.de_o, bus.hs_o, bus.vs_o, bus.frame_done,
                      bus.cfg_err, bus.data_o, bus.out_lines};
        end
      end
      for (int g = 0; g < 3; g++) cyc(g == 1, 1'b0, 1'b0, '0, -1, -1);
    end
  endtask

  // Reference: pixels the stage should emit for a frame, from window geometry.
  function automatic int build_exp(input int w, input int h,
                                   input int sx, input int sy,
                                   input int ex, input int ey,
                                   input bit act, input int rows_lim);
    pix_t p;
    int   lines = 0;
    bit   err   = (sx >= ex) || (sy >= ey);
    exp_q.delete();
    for (int r = 0; r < h && r < rows_lim; r++) begin
      bit hit = 1'b0;
      for (int c = 0; c < w; c++) begin
        bit inw = act && !err && c >= sx && c < ex && r >= sy && r < ey;
        p.r = r; p.c = c; p.d = fdata[r][c];
        if (inw) hit = 1'b1;
`ifdef CROP_FILL_EN
        if (!inw) p.d = FILL;
        if (act) exp_q.push_back(p);
`else
        if (inw) exp_q.push_back(p);
`endif
      end
      if (hit) lines++;
    end
    return lines;
  endfunction

  task automatic set_cfg(input int sx, input int sy, input int ex, input int ey);
    bus.start_x = XW'(sx);
    bus.start_y = YW'(sy);
    bus.end_x   = XW'(ex);
    bus.end_y   = YW'(ey);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b1, 24'($urandom), -1, -1);
    checks++;
    if ({bus.de_o, bus.hs_o, bus.vs_o, bus.frame_done, bus.cfg_err,
         bus.data_o, bus.out_lines} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: de=%b data=%h lines=%0d cfg_err=%b, all required 0",
               bus.de_o, bus.data_o, bus.out_lines, bus.cfg_err);
    end
    rst = 1'b0;
    obs_q.delete();
    sync_bad = 0;
  endtask

  task automatic test_crop_basic();
    int lines_a;
    set_cfg(2, 1, 6, 4);
    send_frame(8, 6);
    lines_a = build_exp(8, 6, 2, 1, 6, 4, 1'b1, 99);
    checks++;
    if (obs_q.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL basic_count: got %0d pixels want %0d", obs_q.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      checks++;
      if (obs_q[i].r !== exp_q[i].r || obs_q[i].c !== exp_q[i].c || obs_q[i].d !== exp_q[i].d) begin
        errors++;
        $display("FAIL basic_pixel %0d: got (%0d,%0d,%h) want (%0d,%0d,%h)", i,
                 obs_q[i].r, obs_q[i].c, obs_q[i].d, exp_q[i].r, exp_q[i].c, exp_q[i].d);
      end
    end
    send_frame(8, 6);
    checks++;
    if (fd_seen !== 1 || lines_seen !== YW'(lines_a)) begin
      errors++;
      $display("FAIL basic_out_lines: done=%0d lines=%0d want done=1 lines=%0d",
               fd_seen, lines_seen, lines_a);
    end
  endtask

  task automatic test_cfg_change();
    int dummy;
    set_cfg(2, 1, 6, 4);
    send_frame(8, 6);
    send_frame(8, 6, 2, XW'(4));
    dummy = build_exp(8, 6, 2, 1, 6, 4, 1'b1, 99);
    checks++;
    if (obs_q.size() !== exp_q.size() || obs_q.size() == 0 || obs_q[0].c !== 2) begin
      errors++;
      $display("FAIL cfg_change_cur: got %0d pixels first_x=%0d want %0d first_x=2",
               obs_q.size(), (obs_q.size() > 0) ? obs_q[0].c : -1, exp_q.size());
    end
    send_frame(8, 6);
    dummy = build_exp(8, 6, 4, 1, 6, 4, 1'b1, 99);
    checks++;
    if (obs_q.size() !== exp_q.size() || obs_q.size() == 0 || obs_q[0].c !== exp_q[0].c) begin
      errors++;
      $display("FAIL cfg_change_next: got %0d pixels first_x=%0d want %0d first_x=%0d",
               obs_q.size(), (obs_q.size() > 0) ? obs_q[0].c : -1, exp_q.size(),
               (exp_q.size() > 0) ? exp_q[0].c : -1);
    end
  endtask

  task automatic test_cfg_err();
    int dummy;
    set_cfg(5, 0, 5, 6);
    send_frame(8, 6);
    dummy = build_exp(8, 6, 5, 0, 5, 6, 1'b1, 99);
    checks++;
    if (bus.cfg_err !== 1'b1) begin
      errors++;
      $display("FAIL cfg_err_flag: got %b want 1", bus.cfg_err);
    end
    checks++;
    if (obs_q.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL cfg_err_pixels: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    set_cfg(3, 2, 0, 5);
    send_frame(8, 6);
    checks++;
    if (fd_seen !== 1 || lines_seen !== '0) begin
      errors++;
      $display("FAIL cfg_err_summary: done=%0d lines=%0d want done=1 lines=0", fd_seen, lines_seen);
    end
    checks++;
    if (bus.cfg_err !== 1'b1) begin
      errors++;
      $display("FAIL cfg_err_end_zero: got %b want 1", bus.cfg_err);
    end
  endtask

  task automatic test_mid_reset();
    int dummy;
    set_cfg(1, 0, 7, 6);
    send_frame(8, 6);
    send_frame(8, 6, -1, '0, 2);
    checks++;
    if (rst_snap !== '0) begin
      errors++;
      $display("FAIL mid_reset_outputs: got %h want 0", rst_snap);
    end
    dummy = build_exp(8, 6, 1, 0, 7, 6, 1'b1, 2);
    checks++;
    if (obs_q.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL mid_reset_pixels: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    send_frame(8, 6);
    dummy = build_exp(8, 6, 1, 0, 7, 6, 1'b1, 99);
    checks++;
    if (obs_q.size() !== exp_q.size() || fd_seen !== 0) begin
      errors++;
      $display("FAIL mid_reset_resume: got %0d pixels done=%0d want %0d done=0",
               obs_q.size(), fd_seen, exp_q.size());
    end
  endtask

  task automatic test_no_vs();
    int dummy;
    rst = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, '0, -1, -1);
    rst = 1'b0;
    set_cfg(0, 0, 8, 6);
    send_frame(8, 6, -1, '0, -1, 1'b1);
    checks++;
    if (obs_q.size() !== 0) begin
      errors++;
      $display("FAIL no_vs_pixels: got %0d want 0", obs_q.size());
    end
    send_frame(8, 6);
    dummy = build_exp(8, 6, 0, 0, 8, 6, 1'b1, 99);
    checks++;
    if (obs_q.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL no_vs_frame2_count: got %0d want %0d", obs_q.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      checks++;
      if (obs_q[i].r !== exp_q[i].r || obs_q[i].c !== exp_q[i].c || obs_q[i].d !== exp_q[i].d) begin
        errors++;
        $display("FAIL no_vs_frame2_pixel %0d: got (%0d,%0d,%h) want (%0d,%0d,%h)", i,
                 obs_q[i].r, obs_q[i].c, obs_q[i].d, exp_q[i].r, exp_q[i].c, exp_q[i].d);
      end
    end
  endtask

  task automatic test_random();
    int prev_lines = 0;
    for (int k = 0; k < 24; k++) begin
      int w  = $urandom_range(4, 12);
      int h  = $urandom_range(3, 10);
      int sx = $urandom_range(0, 13);
      int sy = $urandom_range(0, 11);
      int ex = $urandom_range(0, 13);
      int ey = $urandom_range(0, 11);
      int chg = ($urandom_range(0, 1) == 1) ? $urandom_range(1, h - 1) : -1;
      int cur;
      set_cfg(sx, sy, ex, ey);
      send_frame(w, h, chg, XW'($urandom_range(0, 13)));
      cur = build_exp(w, h, sx, sy, ex, ey, 1'b1, 99);
      checks++;
      if (obs_q.size() !== exp_q.size()) begin
        errors++;
        $display("FAIL rand_count frame %0d: got %0d want %0d", k, obs_q.size(), exp_q.size());
      end else foreach (exp_q[i]) begin
        checks++;
        if (obs_q[i].r !== exp_q[i].r || obs_q[i].c !== exp_q[i].c || obs_q[i].d !== exp_q[i].d) begin
          errors++;
          $display("FAIL rand_pixel f%0d i%0d: got (%0d,%0d,%h) want (%0d,%0d,%h)", k, i,
                   obs_q[i].r, obs_q[i].c, obs_q[i].d, exp_q[i].r, exp_q[i].c, exp_q[i].d);
        end
      end
      if (k > 0) begin
        checks++;
        if (fd_seen !== 1 || lines_seen !== YW'(prev_lines)) begin
          errors++;
          $display("FAIL rand_out_lines frame %0d: done=%0d lines=%0d want done=1 lines=%0d",
                   k, fd_seen, lines_seen, prev_lines);
        end
      end
      prev_lines = cur;
    end
    checks++;
    if (sync_bad !== 0) begin
      errors++;
      $display("FAIL sync_delay: %0d hs/vs cycles wrong, want 0", sync_bad);
    end
  endtask

  initial begin
    bus.hs_i = 1'b0; bus.vs_i = 1'b0; bus.de_i = 1'b0; bus.data_i = '0;
    set_cfg(0, 0, 0, 0);
    sync_bad = 0;
    fd_seen = 0;
    lines_seen = '0;
    rst_snap = '0;
    test_reset();
    test_crop_basic();
    test_cfg_change();
    test_cfg_err();
    test_mid_reset();
    test_no_vs();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
`default_nettype wire
